weights_addr_gen: RTL and testbench

Stream initiator that issues the weight-address sequence consumed by the weights ROM. It sits upstream of the ROM slave port and drives the address stream, framed with sow/eow, through the rts/rtr handshake. One start request issues NB_NEURONS passes of addresses 0..NB_WEIGHTS-1, one pass per neuron, then reports completion. Downstream back-pressure is honoured on every beat.

---
 rtl/weights_addr_gen_pkg.sv | 34 +++
 rtl/weights_addr_gen_wrap_counter.sv | 43 ++++
 rtl/weights_addr_gen.sv | 151 +++++++++++++++
 tb/tb_weights_addr_gen.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/weights_addr_gen_pkg.sv
// -----------------------------------------------------------------------------
// weights_addr_gen_pkg
// Shared types and width helpers for the weight-address generator.
//   addr_gen_state_t : run-control FSM states (IDLE, RUN, DONE)
//   log2()           : ceiling log2, used to size counters and ports
//   addr_width()     : address port width for a given pass length
//   pass_width()     : pass-index port width, never below 1 bit
// -----------------------------------------------------------------------------
package weights_addr_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } addr_gen_state_t;

  function automatic int unsigned log2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  function automatic int unsigned addr_width(input int unsigned nb_weights);
    return log2(nb_weights);
  endfunction

  function automatic int unsigned pass_width(input int unsigned nb_neurons);
    return (log2(nb_neurons) < 1) ? 1 : log2(nb_neurons);
  endfunction

endpackage

// File: rtl/weights_addr_gen_wrap_counter.sv
// -----------------------------------------------------------------------------
// wrap_counter
// Counter 0..MAX that wraps back to 0 after MAX (compare is against MAX, not
// a power of two).
//   clk, rst : clock, asynchronous active-high reset
//   inc_i    : advance by one (wraps at MAX)
//   clr_i    : synchronous clear, has priority over inc_i
//   cnt_o    : current count (registered)
//   last_o   : count currently equals MAX
// -----------------------------------------------------------------------------
module wrap_counter
  import weights_addr_gen_pkg::*;
#(
  parameter int unsigned MAX = 1,
  parameter int unsigned W   = pass_width(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o,
  output logic         last_o
);

  logic [W-1:0] r_cnt;
  logic         w_last;

  assign w_last = (r_cnt == W'(MAX));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr_i) begin
      r_cnt <= '0;
    end else if (inc_i) begin
      r_cnt <= w_last ? '0 : r_cnt + W'(1);
    end
  end

  assign cnt_o  = r_cnt;
  assign last_o = w_last;

endmodule

// File: rtl/weights_addr_gen.sv
// -----------------------------------------------------------------------------
// weights_addr_gen
// Stream initiator for the weights ROM: one start request issues NB_NEURONS
// passes of addresses 0..NB_WEIGHTS-1 over an rts/rtr handshake, framed with
// sow/eow, then pulses done_o. All outputs are registered.
//   clk, rst   : clock, asynchronous active-high reset
//   start_i    : run request, sampled only in IDLE
//   pause_i    : (WEIGHTS_ADDR_GEN_PAUSE_EN only) hold back the next beat
//   busy_o     : run in progress
//   done_o     : one-cycle pulse after the final beat is accepted
//   rtr_i      : downstream ready
//   rts_o      : address beat valid
//   sow_o      : beat is address 0 of a pass
//   eow_o      : beat is address NB_WEIGHTS-1 of a pass
//   address_o  : weight address
//   pass_o     : pass (neuron) index
// Optional feature macro: WEIGHTS_ADDR_GEN_PAUSE_EN adds pause_i.
// -----------------------------------------------------------------------------
module weights_addr_gen
  import weights_addr_gen_pkg::*;
#(
  parameter int unsigned NB_WEIGHTS = 784,
  parameter int unsigned NB_NEURONS = 100
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start_i,
`ifdef WEIGHTS_ADDR_GEN_PAUSE_EN
  input  logic                                pause_i,
`endif
  output logic                                busy_o,
  output logic                                done_o,
  input  logic                                rtr_i,
  output logic                                rts_o,
  output logic                                sow_o,
  output logic                                eow_o,
  output logic [addr_width(NB_WEIGHTS)-1:0]   address_o,
  output logic [pass_width(NB_NEURONS)-1:0]   pass_o
);

  localparam int unsigned AW = addr_width(NB_WEIGHTS);
  localparam int unsigned PW = pass_width(NB_NEURONS);

  addr_gen_state_t r_state;
  logic            r_busy;
  logic            r_done;
  logic            r_rts;
  logic            r_sow;
  logic            r_eow;

  logic            w_pause;
  logic            w_start;
  logic            w_accept;
  logic            w_addr_last;
  logic            w_pass_last;
  logic            w_final;
  logic [AW-1:0]   w_addr;
  logic [PW-1:0]   w_pass;

`ifdef WEIGHTS_ADDR_GEN_PAUSE_EN
  assign w_pause = pause_i;
`else
  assign w_pause = 1'b0;
`endif

  assign w_start  = (r_state == IDLE) && start_i;
  assign w_accept = (r_state == RUN) && r_rts && rtr_i;
  assign w_final  = w_accept && w_addr_last && w_pass_last;

  // Both counters wrap on the final beat, so they are already 0 for the next
  // run; the clear on start is kept so a run always begins from 0/0.
  wrap_counter #(
    .MAX (NB_WEIGHTS - 1),
    .W   (AW)
  ) u_addr_cnt (
    .clk    (clk),
    .rst    (rst),
    .inc_i  (w_accept),
    .clr_i  (w_start),
    .cnt_o  (w_addr),
    .last_o (w_addr_last)
  );

  wrap_counter #(
    .MAX (NB_NEURONS - 1),
    .W   (PW)
  ) u_pass_cnt (
    .clk    (clk),
    .rst    (rst),
    .inc_i  (w_accept && w_addr_last),
    .clr_i  (w_start),
    .cnt_o  (w_pass),
    .last_o (w_pass_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_rts   <= 1'b0;
      r_sow   <= 1'b0;
      r_eow   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start_i) begin
            r_state <= RUN;
            r_busy  <= 1'b1;
            r_rts   <= ~w_pause;
            r_sow   <= 1'b1;
            r_eow   <= 1'b0;
          end
        end
        RUN: begin
          if (w_final) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_rts   <= 1'b0;
            r_sow   <= 1'b0;
            r_eow   <= 1'b0;
          end else if (w_accept) begin
            // sow/eow describe the address the counter moves to on this edge
            r_rts <= ~w_pause;
            r_sow <= w_addr_last;
            r_eow <= !w_addr_last && (w_addr == AW'(NB_WEIGHTS - 2));
          end else if (!r_rts && !w_pause) begin
            r_rts <= 1'b1;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy_o    = r_busy;
  assign done_o    = r_done;
  assign rts_o     = r_rts;
  assign sow_o     = r_sow;
  assign eow_o     = r_eow;
  assign address_o = w_addr;
  assign pass_o    = w_pass;

endmodule

// File: tb/tb_weights_addr_gen.sv
module tb_weights_addr_gen;

  localparam int unsigned SW = 4;
  localparam int unsigned SN = 2;
  localparam int unsigned LW = 784;
  localparam int unsigned LN = 100;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       s_start, s_rtr, s_busy, s_done, s_rts, s_sow, s_eow;
  logic [1:0] s_addr;
  logic [0:0] s_pass;
  logic       l_start, l_rtr, l_busy, l_done, l_rts, l_sow, l_eow;
  logic [9:0] l_addr;
  logic [6:0] l_pass;
`ifdef WEIGHTS_ADDR_GEN_PAUSE_EN
  logic       s_pause;
`endif

  typedef struct {
    int unsigned addr;
    int unsigned pass;
    logic        sow;
    logic        eow;
  } beat_t;

  beat_t sq[$];
  beat_t lq[$];
  int    vecs = 0;
  int    errs = 0;

  weights_addr_gen #(
    .NB_WEIGHTS (SW),
    .NB_NEURONS (SN)
  ) u_small (
    .clk       (clk),
    .rst       (rst),
    .start_i   (s_start),
`ifdef WEIGHTS_ADDR_GEN_PAUSE_EN
    .pause_i   (s_pause),
`endif
    .busy_o    (s_busy),
    .done_o    (s_done),
    .rtr_i     (s_rtr),
    .rts_o     (s_rts),
    .sow_o     (s_sow),
    .eow_o     (s_eow),
    .address_o (s_addr),
    .pass_o    (s_pass)
  );

  weights_addr_gen #(
    .NB_WEIGHTS (LW),
    .NB_NEURONS (LN)
  ) u_large (
    .clk       (clk),
    .rst       (rst),
    .start_i   (l_start),
`ifdef WEIGHTS_ADDR_GEN_PAUSE_EN
    .pause_i   (1'b0),
`endif
    .busy_o    (l_busy),
    .done_o    (l_done),
    .rtr_i     (l_rtr),
    .rts_o     (l_rts),
    .sow_o     (l_sow),
    .eow_o     (l_eow),
    .address_o (l_addr),
    .pass_o    (l_pass)
  );

  // Expected beat sequence of one full run, pushed when the run is started.
  task automatic push_small();
    beat_t b;
    for (int unsigned p = 0; p < SN; p++) begin
      for (int unsigned a = 0; a < SW; a++) begin
        b.addr = a; b.pass = p; b.sow = (a == 0); b.eow = (a == SW - 1);
        sq.push_back(b);
      end
    end
  endtask

  task automatic push_large();
    beat_t b;
    for (int unsigned p = 0; p < LN; p++) begin
      for (int unsigned a = 0; a < LW; a++) begin
        b.addr = a; b.pass = p; b.sow = (a == 0); b.eow = (a == LW - 1);
        lq.push_back(b);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; s_start = 1'b0; s_rtr = 1'b0; l_start = 1'b0; l_rtr = 1'b0;
`ifdef WEIGHTS_ADDR_GEN_PAUSE_EN
    s_pause = 1'b0;
`endif
    repeat (2) @(negedge clk);
    vecs++;
    if ({s_busy, s_done, s_rts, s_sow, s_eow, s_addr, s_pass} !== 8'b0) begin
      errs++;
      $display("FAIL reset_small got %b want 00000000",
               {s_busy, s_done, s_rts, s_sow, s_eow, s_addr, s_pass});
    end
    vecs++;
    if ({l_busy, l_done, l_rts, l_sow, l_eow, l_addr, l_pass} !== 22'b0) begin
      errs++;
      $display("FAIL reset_large got %b want 0",
               {l_busy, l_done, l_rts, l_sow, l_eow, l_addr, l_pass});
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    vecs++;
    if (s_rts !== 1'b0 || s_busy !== 1'b0) begin
      errs++;
      $display("FAIL idle_no_start got rts=%b busy=%b want 0 0", s_rts, s_busy);
    end
  endtask

  task automatic test_back_to_back();
    beat_t b;
    int nb, nd, tdone;
    sq.delete();
    push_small();
    s_rtr = 1'b1; s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    vecs++;
    if (s_busy !== 1'b1 || s_rts !== 1'b1 || s_addr !== 2'd0 || s_sow !== 1'b1) begin
      errs++;
      $display("FAIL start_latency got busy=%b rts=%b addr=%0d sow=%b want 1 1 0 1",
               s_busy, s_rts, s_addr, s_sow);
    end
    nb = 0; nd = 0; tdone = 0;
    for (int k = 1; k < 30; k++) begin
      if (s_done === 1'b1) begin
        nd++;
        if (tdone == 0) tdone = k;
        vecs++;
        if (s_busy !== 1'b0) begin
          errs++;
          $display("FAIL busy_at_done got %b want 0", s_busy);
        end
      end
      if (s_rts && s_rtr) begin
        vecs++;
        if (sq.size() == 0) begin
          errs++;
          $display("FAIL b2b_extra_beat got addr=%0d want none", s_addr);
        end else begin
          b = sq.pop_front();
          nb++;
          if (s_addr !== 2'(b.addr) || s_pass !== 1'(b.pass) || s_sow !== b.sow || s_eow !== b.eow) begin
            errs++;
            $display("FAIL b2b_beat got a=%0d p=%0d sow=%b eow=%b want a=%0d p=%0d sow=%b eow=%b",
                     s_addr, s_pass, s_sow, s_eow, b.addr, b.pass, b.sow, b.eow);
          end
        end
      end
      @(negedge clk);
    end
    vecs++;
    if (nb != 8 || nd != 1 || tdone != 9) begin
      errs++;
      $display("FAIL b2b_totals got beats=%0d dones=%0d done_cycle=%0d want 8 1 9", nb, nd, tdone);
    end
  endtask

  task automatic test_stall();
    beat_t b;
    int nb, nd;
    bit stalled;
    sq.delete();
    push_small();
    s_rtr = 1'b1; s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    nb = 0; nd = 0; stalled = 0;
    for (int k = 0; k < 30; k++) begin
      if (s_done === 1'b1) nd++;
      if (s_rts && s_addr == 2'd2 && !stalled) begin
        stalled = 1;
        s_rtr = 1'b0;
        repeat (3) begin
          @(negedge clk);
          vecs++;
          if (s_addr !== 2'd2 || s_eow !== 1'b0 || s_rts !== 1'b1) begin
            errs++;
            $display("FAIL stall_hold got addr=%0d eow=%b rts=%b want 2 0 1", s_addr, s_eow, s_rts);
          end
        end
        s_rtr = 1'b1;
      end
      if (s_rts && s_rtr) begin
        vecs++;
        if (sq.size() == 0) begin
          errs++;
          $display("FAIL stall_extra_beat got addr=%0d want none", s_addr);
        end else begin
          b = sq.pop_front();
          nb++;
          if (s_addr !== 2'(b.addr) || s_pass !== 1'(b.pass) || s_sow !== b.sow || s_eow !== b.eow) begin
            errs++;
            $display("FAIL stall_beat got a=%0d p=%0d sow=%b eow=%b want a=%0d p=%0d sow=%b eow=%b",
                     s_addr, s_pass, s_sow, s_eow, b.addr, b.pass, b.sow, b.eow);
          end
        end
      end
      @(negedge clk);
    end
    vecs++;
    if (nb != 8 || nd != 1 || !stalled) begin
      errs++;
      $display("FAIL stall_totals got beats=%0d dones=%0d stalled=%0d want 8 1 1", nb, nd, stalled);
    end
  endtask

  task automatic test_ignored_start();
    beat_t b;
    int nb, nd;
    sq.delete();
    push_small();
    s_rtr = 1'b1; s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    nb = 0; nd = 0;
    for (int k = 1; k < 30; k++) begin
      s_start = (k == 4);
      if (s_done === 1'b1) begin
        nd++;
        s_start = 1'b1;
      end
      if (s_rts && s_rtr) begin
        vecs++;
        if (sq.size() == 0) begin
          errs++;
          $display("FAIL ign_extra_beat got addr=%0d want none", s_addr);
        end else begin
          b = sq.pop_front();
          nb++;
          if (s_addr !== 2'(b.addr) || s_pass !== 1'(b.pass)) begin
            errs++;
            $display("FAIL ign_beat got a=%0d p=%0d want a=%0d p=%0d", s_addr, s_pass, b.addr, b.pass);
          end
        end
      end
      @(negedge clk);
    end
    s_start = 1'b0;
    vecs++;
    if (nb != 8 || nd != 1 || s_busy !== 1'b0 || s_rts !== 1'b0) begin
      errs++;
      $display("FAIL ign_totals got beats=%0d dones=%0d busy=%b rts=%b want 8 1 0 0",
               nb, nd, s_busy, s_rts);
    end
  endtask

  task automatic test_reset_midrun();
    beat_t b;
    int nb, nd;
    sq.delete();
    push_small();
    s_rtr = 1'b1; s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    nb = 0;
    for (int k = 0; k < 20 && nb < 5; k++) begin
      if (s_rts && s_rtr) begin
        b = sq.pop_front();
        nb++;
        vecs++;
        if (s_addr !== 2'(b.addr) || s_pass !== 1'(b.pass)) begin
          errs++;
          $display("FAIL pre_rst_beat got a=%0d p=%0d want a=%0d p=%0d", s_addr, s_pass, b.addr, b.pass);
        end
      end
      if (nb < 5) @(negedge clk);
    end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    vecs++;
    if ({s_busy, s_done, s_rts, s_sow, s_eow, s_addr, s_pass} !== 8'b0) begin
      errs++;
      $display("FAIL async_reset got %b want 00000000",
               {s_busy, s_done, s_rts, s_sow, s_eow, s_addr, s_pass});
    end
    @(negedge clk);
    rst = 1'b0;
    nd = 0;
    repeat (10) begin
      @(negedge clk);
      if (s_done === 1'b1 || s_rts === 1'b1) nd++;
    end
    vecs++;
    if (nd != 0) begin
      errs++;
      $display("FAIL post_reset_quiet got active_cycles=%0d want 0", nd);
    end
    test_back_to_back();
  endtask

`ifdef WEIGHTS_ADDR_GEN_PAUSE_EN
  task automatic test_pause();
    beat_t b;
    int nd;
    sq.delete();
    push_small();
    s_pause = 1'b1; s_rtr = 1'b1; s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    repeat (3) begin
      vecs++;
      if (s_rts !== 1'b0 || s_busy !== 1'b1) begin
        errs++;
        $display("FAIL pause_at_start got rts=%b busy=%b want 0 1", s_rts, s_busy);
      end
      @(negedge clk);
    end
    s_pause = 1'b0;
    @(negedge clk);
    vecs++;
    if (s_rts !== 1'b1 || s_addr !== 2'd0) begin
      errs++;
      $display("FAIL pause_release got rts=%b addr=%0d want 1 0", s_rts, s_addr);
    end
    s_rtr = 1'b0; s_pause = 1'b1;
    repeat (2) begin
      @(negedge clk);
      vecs++;
      if (s_rts !== 1'b1 || s_addr !== 2'd0) begin
        errs++;
        $display("FAIL pause_pending_hold got rts=%b addr=%0d want 1 0", s_rts, s_addr);
      end
    end
    s_rtr = 1'b1;
    b = sq.pop_front();
    @(negedge clk);
    repeat (2) begin
      vecs++;
      if (s_rts !== 1'b0 || s_addr !== 2'd1) begin
        errs++;
        $display("FAIL pause_next_held got rts=%b addr=%0d want 0 1", s_rts, s_addr);
      end
      @(negedge clk);
    end
    s_pause = 1'b0;
    nd = 0;
    for (int k = 0; k < 20; k++) begin
      if (s_done === 1'b1) nd++;
      if (s_rts && s_rtr) begin
        vecs++;
        if (sq.size() == 0) begin
          errs++;
          $display("FAIL pause_extra_beat got addr=%0d want none", s_addr);
        end else begin
          b = sq.pop_front();
          if (s_addr !== 2'(b.addr) || s_pass !== 1'(b.pass)) begin
            errs++;
            $display("FAIL pause_beat got a=%0d p=%0d want a=%0d p=%0d", s_addr, s_pass, b.addr, b.pass);
          end
        end
      end
      @(negedge clk);
    end
    vecs++;
    if (nd != 1 || sq.size() != 0) begin
      errs++;
      $display("FAIL pause_totals got dones=%0d left=%0d want 1 0", nd, sq.size());
    end
  endtask
`endif

  task automatic test_long_random();
    beat_t b;
    int nb;
    bit seen_done;
    lq.delete();
    push_large();
    l_rtr = 1'b1; l_start = 1'b1;
    @(negedge clk);
    l_start = 1'b0;
    nb = 0; seen_done = 0;
    for (int k = 0; k < 90000 && !seen_done; k++) begin
      if (l_done === 1'b1) begin
        seen_done = 1;
      end else begin
        l_rtr = ($urandom_range(0, 63) != 0);
        if (l_rts && l_rtr) begin
          vecs++;
          if (lq.size() == 0) begin
            errs++;
            $display("FAIL long_extra_beat got addr=%0d want none", l_addr);
          end else begin
            b = lq.pop_front();
            nb++;
            if (l_addr !== 10'(b.addr) || l_pass !== 7'(b.pass) || l_sow !== b.sow || l_eow !== b.eow) begin
              errs++;
              $display("FAIL long_beat got a=%0d p=%0d sow=%b eow=%b want a=%0d p=%0d sow=%b eow=%b",
                       l_addr, l_pass, l_sow, l_eow, b.addr, b.pass, b.sow, b.eow);
            end
          end
        end
        @(negedge clk);
      end
    end
    vecs++;
    if (!seen_done || nb != int'(LW * LN) || lq.size() != 0) begin
      errs++;
      $display("FAIL long_totals got done=%0d beats=%0d left=%0d want 1 %0d 0",
               seen_done, nb, lq.size(), LW * LN);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_stall();
    test_ignored_start();
    test_reset_midrun();
`ifdef WEIGHTS_ADDR_GEN_PAUSE_EN
    test_pause();
`endif
    test_long_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
